// File: rtl/game_state_controller.sv
// Game-flow FSM (IDLE/PLAY/CRASH/OVER): button commands, score/level, LFSR and play_rst pulse.
// Optional best-score register enabled by defining HISCORE_EN; otherwise hiscore is tied to zero.
module game_state_controller #(
  parameter int         LEVEL_UP_FRAMES = 1800,
  parameter int         CRASH_FRAMES    = 120,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  input  logic [9:0]  Pixel_row,
  input  logic [9:0]  Pixel_column,
  input  logic        collison_detect,
  output logic [7:0]  game_info_reg,
  output logic [7:0]  randomized_value,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        play_rst
);

  typedef enum logic [1:0] {IDLE, PLAY, CRASH, OVER} state_t;

  localparam logic [15:0] LVL_LAST   = 16'(LEVEL_UP_FRAMES - 1);
  localparam logic [15:0] CRASH_LAST = 16'(CRASH_FRAMES - 1);

  state_t      state, state_nx;
  logic        match, match_d, frame_tick;
  logic        btn_left_d, btn_right_d, btn_start_d;
  logic        rise_left, rise_right, rise_start;
  logic [1:0]  move, move_nx;
  logic [1:0]  icon, icon_nx;
  logic        level, level_nx;
  logic        done, done_nx;
  logic [15:0] score_q, score_nx;
  logic [15:0] frame_cnt, frame_cnt_nx;
  logic        play_rst_nx;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic [7:0]  lfsr;

  assign match = (Pixel_row == 10'd0) && (Pixel_column == 10'd0);

  // Rise pulses are registered so a press acts one clock after the _d stage sees it
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      match_d     <= 1'b0;
      frame_tick  <= 1'b0;
      btn_left_d  <= 1'b0;
      btn_right_d <= 1'b0;
      btn_start_d <= 1'b0;
      rise_left   <= 1'b0;
      rise_right  <= 1'b0;
      rise_start  <= 1'b0;
    end else begin
      match_d     <= match;
      frame_tick  <= match & ~match_d;
      btn_left_d  <= btn_left;
      btn_right_d <= btn_right;
      btn_start_d <= btn_start;
      rise_left   <= btn_left & ~btn_left_d;
      rise_right  <= btn_right & ~btn_right_d;
      rise_start  <= btn_start & ~btn_start_d;
    end
  end

  assign score_sum = {1'b0, score_q} + (level ? 17'd2 : 17'd1);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_nx     = state;
    move_nx      = 2'b00;
    icon_nx      = icon;
    level_nx     = level;
    done_nx      = done;
    score_nx     = score_q;
    frame_cnt_nx = frame_cnt;
    play_rst_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise_left && !rise_right)
          icon_nx = icon - 2'd1;
        else if (rise_right && !rise_left)
          icon_nx = icon + 2'd1;
        if (rise_start) begin
          state_nx     = PLAY;
          score_nx     = 16'd0;
          level_nx     = 1'b0;
          frame_cnt_nx = 16'd0;
        end
      end
      PLAY: begin
        // Collision pre-empts any score or level update arriving on the same tick
        if (collison_detect) begin
          state_nx     = CRASH;
          frame_cnt_nx = 16'd0;
        end else begin
          move_nx = (btn_left && btn_right) ? 2'b00 : {btn_left, btn_right};
          if (frame_tick) begin
            score_nx = score_sat;
            if (frame_cnt == LVL_LAST)
              level_nx = 1'b1;
            else
              frame_cnt_nx = frame_cnt + 16'd1;
          end
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (frame_cnt == CRASH_LAST) begin
            state_nx = OVER;
            done_nx  = 1'b1;
          end else begin
            frame_cnt_nx = frame_cnt + 16'd1;
          end
        end
      end
      OVER: begin
        if (rise_start) begin
          state_nx    = IDLE;
          play_rst_nx = 1'b1;
          done_nx     = 1'b0;
          level_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      move      <= 2'b00;
      icon      <= 2'b00;
      level     <= 1'b0;
      done      <= 1'b0;
      score_q   <= 16'd0;
      frame_cnt <= 16'd0;
      play_rst  <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_nx;
      move      <= move_nx;
      icon      <= icon_nx;
      level     <= level_nx;
      done      <= done_nx;
      score_q   <= score_nx;
      frame_cnt <= frame_cnt_nx;
      play_rst  <= play_rst_nx;
      lfsr      <= (lfsr == 8'd0) ? LFSR_SEED
                                  : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign game_info_reg    = {done, icon, level, 2'b00, move};
  assign randomized_value = lfsr;
  assign score            = score_q;

`ifdef HISCORE_EN
  logic [15:0] hiscore_q;
  logic        hs_update;

  assign hs_update = (state == CRASH) && (state_nx == OVER);

  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      hiscore_q <= 16'd0;
    else if (hs_update && (score_q > hiscore_q))
      hiscore_q <= score_q;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 16'h0000;
`endif

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Game-flow controller that produces `game_info_reg` and `randomized_value` for `video_game_controller` and consumes its `collison_detect`. It converts debounced push-button levels into move, icon-select and level commands, and runs the IDLE/PLAY/CRASH/OVER game state machine. It keeps the score and issues a one-cycle `play_rst` pulse that clears the display controller's sticky collision flag before each new game.

## Interface
- `LEVEL_UP_FRAMES`, 1800, frames spent in PLAY before `game_info_reg[4]` sets (30 s at 60 Hz)
- `CRASH_FRAMES`, 120, frames spent in CRASH before OVER
- `LFSR_SEED`, 8'hA5, LFSR reset value; must be nonzero
- `clock`  in  1  25 MHz pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `btn_left`, `btn_right`, `btn_start`  in  1 each  debounced, clock-synchronous button levels
- `Pixel_row`, `Pixel_column`  in  10 each  current pixel address from the DTG
- `collison_detect`  in  1  sticky collision flag from the display controller
- `game_info_reg`  out  8  fields: [1:0] move (10 = left, 01 = right, 00 = none), [3:2] = 0, [4] level, [6:5] icon select, [7] game completed
- `randomized_value`  out  8  LFSR value
- `score`  out  16  current score
- `hiscore`  out  16  best score (see Configuration)
- `play_rst`  out  1  one-cycle pulse; drive into the display controller's `rst`

## Operation
- frame_tick: `match = (Pixel_row==0 && Pixel_column==0)`; `frame_tick = match & ~match_d`, registered. It fires once per frame.
- Edge detect: `btn_*_d` registers; `rise_x = btn_x & ~btn_x_d`.
- FSM states: IDLE (reset state), PLAY, CRASH, OVER.
  - IDLE:
    - `rise_left` decrements [6:5] modulo 4; `rise_right` increments it. Both in the same cycle: no change.
    - `rise_start` moves to PLAY and clears score, level bit, and frame counter.
  - PLAY:
    - [1:0] = {btn_left, btn_right} registered each cycle; both pressed gives 00.
    - On each frame_tick, score += 1, or += 2 when [4]=1; score saturates at 16'hFFFF.
    - On each frame_tick, the frame counter increments. On the tick where the counter equals LEVEL_UP_FRAMES-1, [4] is set and the counter holds.
    - `collison_detect`=1 in any cycle moves to CRASH and clears the frame counter.
  - CRASH: [1:0] forced to 00; score frozen. After CRASH_FRAMES frame_ticks, move to OVER.
  - OVER: [7]=1; [1:0]=00. `rise_start` moves to IDLE, asserts `play_rst` for exactly one cycle, and clears [7] and [4].
- [6:5] holds its value through PLAY, CRASH and OVER; only IDLE changes it.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), shifts every clock in all states. If the state is ever 0, it loads LFSR_SEED.
- Simultaneous events:
  - Collision and level-up tick in the same cycle: collision wins and [4] is not set.
  - Collision and score tick in the same cycle: score is not incremented.
  - `rise_start` and frame_tick together in IDLE: PLAY is entered with counter = 0 and score = 0.

## Timing
- All outputs are registered.
- Reset values: `game_info_reg`=8'h00, `randomized_value`=LFSR_SEED, `score`=0, `hiscore`=0, `play_rst`=0, state IDLE.
- Button level to `game_info_reg[1:0]`: 1-cycle latency.
- Button rise to state change or field update: visible 2 clocks after the button goes high (one clock for the `_d` register, one for the state register).
- `collison_detect` to CRASH, with [1:0]=00: 1 clock.
- `play_rst` is high for exactly one clock, on the clock the FSM enters IDLE.
- `rst` asserted mid-game: all state and outputs return to reset values immediately (asynchronous). Deassertion is used synchronously.

## Configuration
- `HISCORE_EN` defined:
  - On the transition CRASH→OVER, if score > hiscore, then hiscore ← score.
  - hiscore is cleared only by `rst`.
- `HISCORE_EN` undefined: `hiscore` is tied to 16'h0000 and no register is inferred.

## Test plan
- Reset: after `rst` pulse, `game_info_reg`=8'h00, `randomized_value`=8'hA5, `score`=0. After 255 clocks, the LFSR returns to 8'hA5 (maximal length).
- Icon select in IDLE: three `btn_right` presses give [6:5]=11. One `btn_left` press then gives 10. Both pressed together leave 10.
- Start and move: `btn_start` rise → PLAY. Hold `btn_left` → `game_info_reg[1:0]`=10 one clock later. Hold both buttons → 00.
- Score and level (LEVEL_UP_FRAMES=4): run 6 frame_ticks in PLAY. Expect [4]=1 after the 4th tick and `score`=4+2+2=8.
- Crash (CRASH_FRAMES=2): `collison_detect`=1 → CRASH next clock with [1:0]=00. After 2 frame_ticks, [7]=1. With `HISCORE_EN`, `hiscore` equals the final score.
- Restart and mid-game reset:
  - In OVER, `btn_start` rise gives a single-clock `play_rst`, state IDLE, and [7]=0.
  - Asserting `rst` mid-PLAY clears `score` and `game_info_reg` without waiting for a clock edge.
